// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: byte-lane writes, WAIT_STATES wait cycles per OKAY beat, 2-cycle ERROR for bad beats.
// Backpressure is through HREADY only. Read data comes straight from the array, so a write is visible to the next beat.
module ahb_sram_slave #(
    parameter int                           AHB_DATA_WIDTH    = 64,
    parameter int                           AHB_ADDRESS_WIDTH = 32,
    parameter int                           MEM_BYTES         = 4096,
    parameter logic [AHB_ADDRESS_WIDTH-1:0] BASE_ADDR         = '0,
    parameter int                           WAIT_STATES       = 1
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic [AHB_ADDRESS_WIDTH-1:0] HADDR,
    input  logic                         HWRITE,
    input  logic [2:0]                   HSIZE,
    input  logic [2:0]                   HBURST,
    input  logic [1:0]                   HTRANS,
    input  logic [AHB_DATA_WIDTH-1:0]    HWDATA,
    output logic                         HREADY,
    output logic                         HRESP,
    output logic [AHB_DATA_WIDTH-1:0]    HRDATA
);

    localparam int AW    = AHB_ADDRESS_WIDTH;
    localparam int DW    = AHB_DATA_WIDTH;
    localparam int NB    = DW / 8;
    localparam int LB    = $clog2(NB);
    localparam int WORDS = MEM_BYTES / NB;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [AW:0] MEM_LIMIT = (AW+1)'(MEM_BYTES);
    localparam logic [3:0]  WS        = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t         state;
    logic [3:0]     wait_cnt;
    logic [IW-1:0]  word_q;
    logic [NB-1:0]  be_q;
    logic           write_q;
    logic           hready_q;
    logic           hresp_q;

    logic [DW-1:0]  mem [WORDS];

    logic [AW:0]    rel;
    logic [LB-1:0]  lane_off;
    logic [7:0]     size_mask;
    logic           active;
    logic           addr_err;
    logic [NB-1:0]  lane_be;
    logic           commit;
    logic           unused_bits;

    // Extra top bit makes an address below BASE_ADDR show up as a huge offset.
    assign rel       = {1'b0, HADDR} - {1'b0, BASE_ADDR};
    assign lane_off  = HADDR[LB-1:0];
    assign size_mask = (8'd1 << HSIZE) - 8'd1;
    assign active    = HTRANS[1];
    assign addr_err  = rel[AW] | (rel >= MEM_LIMIT) | (HSIZE > 3'(LB)) |
                       (|(lane_off & size_mask[LB-1:0]));

    always_comb begin
        lane_be = '0;
        for (int i = 0; i < NB; i++) begin
            if (i >= int'(lane_off) && i < int'(lane_off) + (1 << HSIZE))
                lane_be[i] = 1'b1;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            word_q   <= '0;
            be_q     <= '0;
            write_q  <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
        end else if (state == S_DATA && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
            hready_q <= (wait_cnt == 4'd1);
        end else if (state == S_ERR1) begin
            state    <= S_ERR2;
            hready_q <= 1'b1;
            hresp_q  <= 1'b1;
        end else begin
            // HREADY is high here (IDLE, ERR2, last DATA cycle): sample the address phase.
            if (active && addr_err) begin
                state    <= S_ERR1;
                hready_q <= 1'b0;
                hresp_q  <= 1'b1;
            end else if (active) begin
                state    <= S_DATA;
                wait_cnt <= WS;
                word_q   <= rel[LB +: IW];
                be_q     <= lane_be;
                write_q  <= HWRITE;
                hready_q <= (WS == 4'd0);
                hresp_q  <= 1'b0;
            end else begin
                state    <= S_IDLE;
                hready_q <= 1'b1;
                hresp_q  <= 1'b0;
            end
        end
    end

    assign commit = (state == S_DATA) && (wait_cnt == 4'd0) && write_q;

    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int i = 0; i < NB; i++) begin
                if (be_q[i])
                    mem[word_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HREADY = hready_q;
    assign HRESP  = hresp_q;
    assign HRDATA = (state == S_DATA && !write_q) ? mem[word_q] : '0;

    assign unused_bits = ^{HBURST, rel};

endmodule
